// File: rtl/riscv_pkg.sv
// Shared RV32I memory-stage types: funct3 encodings, MEM FSM states, MEM/WB bundle and access-size helpers.
package riscv_pkg;

  localparam int RV_XLEN  = 32;
  localparam int RV_REG_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, ACCESS} mem_state_e;

  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_e;

  typedef struct packed {
    logic                valid;
    logic [RV_XLEN-1:0]  address;
    logic [RV_XLEN-1:0]  lmd;
    logic                mem_to_reg;
    logic [RV_REG_W-1:0] rd;
    logic                reg_write;
  } mem_wb_t;

  // Loads and stores share funct3 values but not the same legal set; anything unlisted is a word access.
  function automatic mem_size_e access_size(input logic [2:0] f3, input logic is_load);
    access_size = SZ_WORD;
    if (is_load) begin
      if (f3 == F3_LB || f3 == F3_LBU)      access_size = SZ_BYTE;
      else if (f3 == F3_LH || f3 == F3_LHU) access_size = SZ_HALF;
    end else begin
      if (f3 == F3_SB)      access_size = SZ_BYTE;
      else if (f3 == F3_SH) access_size = SZ_HALF;
    end
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] lane);
    case (size)
      SZ_HALF: is_misaligned = lane[0];
      SZ_WORD: is_misaligned = |lane;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] align_lane(input mem_size_e size, input logic [1:0] lane);
    case (size)
      SZ_HALF: align_lane = {lane[1], 1'b0};
      SZ_WORD: align_lane = 2'b00;
      default: align_lane = lane;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational load extract/sign-extend and store lane replication/byte-enable generation.
module mem_align
  import riscv_pkg::*;
(
  input  mem_size_e          size,
  input  logic [1:0]         lane,
  input  logic               sign_ext,
  input  logic [RV_XLEN-1:0] rdata,
  input  logic [RV_XLEN-1:0] store_src,
  output logic [RV_XLEN-1:0] load_data,
  output logic [RV_XLEN-1:0] store_data,
  output logic [3:0]         store_be
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    store_data = store_src;
    store_be   = 4'b1111;
    case (size)
      SZ_BYTE: begin
        store_data = {4{store_src[7:0]}};
        store_be   = 4'b0001 << lane;
      end
      SZ_HALF: begin
        store_data = {2{store_src[15:0]}};
        store_be   = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        store_data = store_src;
        store_be   = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// RV32I MEM stage: ALU ops reach MEM/WB in 1 cycle; loads/stores hold mem_stall until dmem_ready (min 2 cycles).
// MEM_STAGE_MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and pulse mem_misalign instead of being force-aligned.
module memory_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  input  logic [2:0]            ex_funct3,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [XLEN-1:0]       dmem_rdata,
  input  logic                  dmem_ready,
  output logic                  wb_valid,
  output logic [XLEN-1:0]       wb_address,
  output logic [XLEN-1:0]       wb_lmd,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_write,
  output logic                  mem_misalign
);

  mem_state_e            state;
  logic [XLEN-1:0]       cap_addr;
  logic [XLEN-1:0]       cap_wdata;
  logic [2:0]            cap_funct3;
  logic [REG_ADDR_W-1:0] cap_rd;
  logic                  cap_load;
  logic                  cap_store;
  logic                  cap_reg_write;
  logic                  cap_mem_to_reg;
  mem_wb_t               wb_q;
  mem_size_e             cap_size;
  logic [1:0]            cap_lane;
  logic [XLEN-1:0]       load_data;
  logic [XLEN-1:0]       store_data;
  logic [3:0]            store_be;
  logic                  in_access;
  logic                  ex_mem_op;
  logic                  ex_trap;

  assign in_access = (state == ACCESS);
  assign ex_mem_op = ex_mem_read | ex_mem_write;
  assign cap_size  = access_size(cap_funct3, cap_load);
  // Forcing alignment only ever touches the lane; the word address already drops [1:0].
  assign cap_lane  = align_lane(cap_size, cap_addr[1:0]);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic misalign_q;

  assign ex_trap = ex_valid & ex_mem_op
                 & is_misaligned(access_size(ex_funct3, ex_mem_read), ex_alu_result[1:0]);

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= ~in_access & ex_trap;
  end

  assign mem_misalign = misalign_q;
`else
  assign ex_trap      = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  mem_align u_align (
    .size       (cap_size),
    .lane       (cap_lane),
    .sign_ext   (~cap_funct3[2]),
    .rdata      (dmem_rdata),
    .store_src  (cap_wdata),
    .load_data  (load_data),
    .store_data (store_data),
    .store_be   (store_be)
  );

  assign dmem_req   = in_access;
  assign dmem_we    = in_access & cap_store;
  assign dmem_addr  = {cap_addr[XLEN-1:2], 2'b00};
  assign dmem_wdata = store_data;
  assign dmem_be    = dmem_we ? store_be : 4'b0000;
  assign mem_stall  = in_access ? ~dmem_ready : (ex_valid & ex_mem_op & ~ex_trap);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wb_q           <= '0;
      cap_addr       <= '0;
      cap_wdata      <= '0;
      cap_funct3     <= '0;
      cap_rd         <= '0;
      cap_load       <= 1'b0;
      cap_store      <= 1'b0;
      cap_reg_write  <= 1'b0;
      cap_mem_to_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wb_q.valid     <= 1'b0;
          wb_q.reg_write <= 1'b0;
          if (ex_valid) begin
            if (ex_trap) begin
              wb_q <= '{valid: 1'b1, address: ex_alu_result, lmd: '0,
                        mem_to_reg: ex_mem_to_reg, rd: ex_rd, reg_write: 1'b0};
            end else if (ex_mem_op) begin
              cap_addr       <= ex_alu_result;
              cap_wdata      <= ex_store_data;
              cap_funct3     <= ex_funct3;
              cap_rd         <= ex_rd;
              cap_load       <= ex_mem_read;
              cap_store      <= ex_mem_write & ~ex_mem_read;
              cap_reg_write  <= ex_reg_write;
              cap_mem_to_reg <= ex_mem_to_reg;
              state          <= ACCESS;
            end else begin
              wb_q <= '{valid: 1'b1, address: ex_alu_result, lmd: '0,
                        mem_to_reg: ex_mem_to_reg, rd: ex_rd, reg_write: ex_reg_write};
            end
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            wb_q <= '{valid: 1'b1, address: cap_addr,
                      lmd: cap_store ? '0 : load_data,
                      mem_to_reg: cap_mem_to_reg, rd: cap_rd,
                      reg_write: cap_reg_write & ~cap_store};
            state <= IDLE;
          end else begin
            wb_q.valid     <= 1'b0;
            wb_q.reg_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wb_valid      = wb_q.valid;
  assign wb_address    = wb_q.address;
  assign wb_lmd        = wb_q.lmd;
  assign wb_mem_to_reg = wb_q.mem_to_reg;
  assign wb_rd         = wb_q.rd;
  assign wb_reg_write  = wb_q.reg_write;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios with literal expectations, then random traffic against a transaction-level model.
module tb_memory_stage;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [4:0]  ex_rd;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        wb_valid;
  logic [31:0] wb_address;
  logic [31:0] wb_lmd;
  logic        wb_mem_to_reg;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        mem_misalign;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] memarr [64];
  assign dmem_rdata = memarr[dmem_addr[7:2]];

  always #5 clk = ~clk;

  memory_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_funct3     (ex_funct3),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_rd         (ex_rd),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .wb_valid      (wb_valid),
    .wb_address    (wb_address),
    .wb_lmd        (wb_lmd),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .mem_misalign  (mem_misalign)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbytes(input logic [2:0] f3, input logic is_load);
    if (is_load) return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    int n;
    int sh;
    logic [31:0] v;
    n = nbytes(f3, 1'b1);
    if (n == 4) return w;
    sh = (n == 1) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    v  = (w >> sh) & ((n == 1) ? 32'h0000_00FF : 32'h0000_FFFF);
    if (!f3[2] && v >= ((n == 1) ? 32'h80 : 32'h8000))
      v = v | ((n == 1) ? 32'hFFFF_FF00 : 32'hFFFF_0000);
    return v;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input int n);
    if (n == 1) return (sd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input int n);
    if (n == 1) return 4'(1 << a[1:0]);
    if (n == 2) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic bit trap_cond(input logic [31:0] a, input logic [2:0] f3, input logic is_load);
    return TRAP_EN && ((int'(a[1:0]) % nbytes(f3, is_load)) != 0);
  endfunction

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic [2:0]  f3;
    logic        load;
    logic        store;
    logic        rw;
    logic        m2r;
    logic [4:0]  rd;
  } req_t;

  req_t        cap;
  bit          m_pending = 1'b0;
  logic        e_valid = 1'b0, e_rw = 1'b0, e_m2r = 1'b0, e_mis = 1'b0;
  logic [31:0] e_addr = '0, e_lmd = '0;
  logic [4:0]  e_rd = '0;

  always @(posedge clk) begin : model
    if (rst) begin
      m_pending = 1'b0;
      e_valid = 1'b0; e_rw = 1'b0; e_m2r = 1'b0; e_mis = 1'b0;
      e_addr = '0; e_lmd = '0; e_rd = '0;
    end else begin
      e_mis = 1'b0;
      if (m_pending) begin
        if (dmem_ready) begin
          e_valid   = 1'b1;
          e_addr    = cap.alu;
          e_rd      = cap.rd;
          e_m2r     = cap.m2r;
          e_rw      = cap.store ? 1'b0 : cap.rw;
          e_lmd     = cap.store ? 32'h0 : fmt_load(memarr[cap.alu[7:2]], cap.alu, cap.f3);
          m_pending = 1'b0;
        end else begin
          e_valid = 1'b0;
          e_rw    = 1'b0;
        end
      end else if (ex_valid && (ex_mem_read || ex_mem_write)) begin
        if (trap_cond(ex_alu_result, ex_funct3, ex_mem_read)) begin
          e_valid = 1'b1; e_addr = ex_alu_result; e_lmd = '0; e_rd = ex_rd;
          e_m2r = ex_mem_to_reg; e_rw = 1'b0; e_mis = 1'b1;
        end else begin
          cap.alu   = ex_alu_result;
          cap.sdata = ex_store_data;
          cap.f3    = ex_funct3;
          cap.load  = ex_mem_read;
          cap.store = ex_mem_write && !ex_mem_read;
          cap.rw    = ex_reg_write;
          cap.m2r   = ex_mem_to_reg;
          cap.rd    = ex_rd;
          m_pending = 1'b1;
          e_valid   = 1'b0;
          e_rw      = 1'b0;
        end
      end else if (ex_valid) begin
        e_valid = 1'b1; e_addr = ex_alu_result; e_lmd = '0; e_rd = ex_rd;
        e_m2r = ex_mem_to_reg; e_rw = ex_reg_write;
      end else begin
        e_valid = 1'b0;
        e_rw    = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic x_stall;
    int   n;
    x_stall = m_pending ? !dmem_ready
                        : (ex_valid && (ex_mem_read || ex_mem_write)
                           && !trap_cond(ex_alu_result, ex_funct3, ex_mem_read));
    check("mem_stall", 32'(mem_stall), 32'(x_stall));
    check("dmem_req", 32'(dmem_req), 32'(m_pending));
    check("dmem_we", 32'(dmem_we), 32'(m_pending && cap.store));
    check("mem_misalign", 32'(mem_misalign), 32'(e_mis));
    check("wb_valid", 32'(wb_valid), 32'(e_valid));
    check("wb_reg_write", 32'(wb_reg_write), 32'(e_rw));
    if (e_valid) begin
      check("wb_address", wb_address, e_addr);
      check("wb_lmd", wb_lmd, e_lmd);
      check("wb_rd", 32'(wb_rd), 32'(e_rd));
      check("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(e_m2r));
    end
    if (m_pending) begin
      n = nbytes(cap.f3, cap.load);
      check("dmem_addr", dmem_addr, cap.alu & 32'hFFFF_FFFC);
      if (cap.store) begin
        check("dmem_be", 32'(dmem_be), 32'(exp_be(cap.alu, n)));
        check("dmem_wdata", dmem_wdata, exp_wdata(cap.sdata, n));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mem(input logic [2:0] f3, input logic rd_op, input logic wr_op,
                        input logic [31:0] a, input logic [31:0] sd, input int delay,
                        output logic stall_first, output int req_cycles,
                        output logic [31:0] o_addr, output logic [31:0] o_wdata,
                        output logic [3:0] o_be, output logic o_we);
    ex_valid = 1'b1; ex_funct3 = f3; ex_mem_read = rd_op; ex_mem_write = wr_op;
    ex_alu_result = a; ex_store_data = sd; ex_rd = 5'd7; ex_reg_write = 1'b1;
    ex_mem_to_reg = rd_op; dmem_ready = 1'b0;
    #2 stall_first = mem_stall;
    tick();
    ex_valid = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < delay; i++) begin
      #2 if (dmem_req) req_cycles++;
      tick();
    end
    dmem_ready = 1'b1;
    #2 if (dmem_req) req_cycles++;
    o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
    tick();
    dmem_ready = 1'b0;
    #2;
  endtask

  initial begin
    logic        sf, owe;
    int          rc;
    logic [31:0] oa, ow;
    logic [3:0]  ob;
    logic [1:0]  kind;

    rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_funct3 = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    ex_rd = '0; dmem_ready = 1'b0;
    for (int i = 0; i < 64; i++) memarr[i] = $urandom;

    tick(); tick();
    #2;
    check("reset wb_valid", 32'(wb_valid), 32'h0);
    check("reset wb_address", wb_address, 32'h0);
    check("reset wb_lmd", wb_lmd, 32'h0);
    check("reset wb_reg_write", 32'(wb_reg_write), 32'h0);
    check("reset wb_rd", 32'(wb_rd), 32'h0);
    check("reset dmem_req", 32'(dmem_req), 32'h0);
    check("reset dmem_be", 32'(dmem_be), 32'h0);
    check("reset mem_misalign", 32'(mem_misalign), 32'h0);
    rst = 1'b0;

    // ALU passthrough
    ex_valid = 1'b1; ex_alu_result = 32'h1234_5678; ex_rd = 5'd1; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b0;
    #2 check("alu stall", 32'(mem_stall), 32'h0);
    tick();
    ex_valid = 1'b0;
    #2;
    check("alu wb_valid", 32'(wb_valid), 32'h1);
    check("alu wb_address", wb_address, 32'h1234_5678);
    check("alu wb_rd", 32'(wb_rd), 32'h1);
    check("alu wb_reg_write", 32'(wb_reg_write), 32'h1);
    tick();

    // LW with two wait cycles
    memarr[0] = 32'h8765_4321;
    do_mem(3'b010, 1'b1, 1'b0, 32'h100, 32'h0, 2, sf, rc, oa, ow, ob, owe);
    check("lw stall first", 32'(sf), 32'h1);
    check("lw req cycles", 32'(rc), 32'd3);
    check("lw dmem_addr", oa, 32'h100);
    check("lw dmem_we", 32'(owe), 32'h0);
    check("lw wb_valid", 32'(wb_valid), 32'h1);
    check("lw wb_lmd", wb_lmd, 32'h8765_4321);
    check("lw wb_mem_to_reg", 32'(wb_mem_to_reg), 32'h1);
    check("lw wb_reg_write", 32'(wb_reg_write), 32'h1);

    // LB / LBU at lane 3
    memarr[0] = 32'h80FF_FFFF;
    do_mem(3'b000, 1'b1, 1'b0, 32'h103, 32'h0, 0, sf, rc, oa, ow, ob, owe);
    check("lb wb_lmd", wb_lmd, 32'hFFFF_FF80);
    do_mem(3'b100, 1'b1, 1'b0, 32'h103, 32'h0, 1, sf, rc, oa, ow, ob, owe);
    check("lbu wb_lmd", wb_lmd, 32'h0000_0080);

    // SB at lane 2
    do_mem(3'b000, 1'b0, 1'b1, 32'h202, 32'h0000_00AB, 1, sf, rc, oa, ow, ob, owe);
    check("sb dmem_we", 32'(owe), 32'h1);
    check("sb dmem_be", 32'(ob), 32'h4);
    check("sb dmem_wdata", ow, 32'hABAB_ABAB);
    check("sb wb_valid", 32'(wb_valid), 32'h1);
    check("sb wb_reg_write", 32'(wb_reg_write), 32'h0);

    // reset while an access is outstanding
    ex_valid = 1'b1; ex_funct3 = 3'b010; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_alu_result = 32'h40; ex_rd = 5'd3;
    tick();
    ex_valid = 1'b0;
    #2 check("pre-reset dmem_req", 32'(dmem_req), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("abort dmem_req", 32'(dmem_req), 32'h0);
    check("abort wb_valid", 32'(wb_valid), 32'h0);
    dmem_ready = 1'b1;
    tick();
    #2;
    check("idle ready wb_valid", 32'(wb_valid), 32'h0);
    check("idle ready dmem_req", 32'(dmem_req), 32'h0);
    dmem_ready = 1'b0;
    tick();

    // misaligned LW at 0x101
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ex_valid = 1'b1; ex_funct3 = 3'b010; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
    ex_alu_result = 32'h101; ex_rd = 5'd9; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
    #2 check("trap stall", 32'(mem_stall), 32'h0);
    tick();
    ex_valid = 1'b0;
    #2;
    check("trap dmem_req", 32'(dmem_req), 32'h0);
    check("trap mem_misalign", 32'(mem_misalign), 32'h1);
    check("trap wb_valid", 32'(wb_valid), 32'h1);
    check("trap wb_reg_write", 32'(wb_reg_write), 32'h0);
    tick();
    #2 check("trap pulse end", 32'(mem_misalign), 32'h0);
`else
    memarr[0] = 32'hCAFE_F00D;
    do_mem(3'b010, 1'b1, 1'b0, 32'h101, 32'h0, 0, sf, rc, oa, ow, ob, owe);
    check("misalign dmem_addr", oa, 32'h100);
    check("misalign wb_lmd", wb_lmd, 32'hCAFE_F00D);
    check("misalign flag", 32'(mem_misalign), 32'h0);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      ex_valid      = ($urandom_range(0, 3) != 0);
      kind          = 2'($urandom_range(0, 3));
      ex_mem_read   = kind[0];
      ex_mem_write  = kind[1];
      ex_funct3     = 3'($urandom_range(0, 7));
      ex_alu_result = $urandom;
      ex_store_data = $urandom;
      ex_rd         = 5'($urandom_range(0, 31));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_to_reg = 1'($urandom_range(0, 1));
      dmem_ready    = ($urandom_range(0, 2) == 0);
      tick();
    end
    rst = 1'b0; ex_valid = 1'b0; dmem_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, between execute and writeback.
- Takes the EX/MEM bundle and runs load/store accesses on a req/ready data-memory port.
- Aligns and sign-extends load data, generates store byte enables, and stalls upstream while an access is outstanding.
- Drives the MEM/WB register whose outputs map onto memory_writeback_if fields address, LMD and mem_to_reg.

Parameters:
- XLEN, 32, data/address width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock (single clock domain).
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_alu_result  in  XLEN  ALU result / effective address.
- ex_store_data  in  XLEN  rs2 value for stores.
- ex_funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW).
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_reg_write  in  1  writes rd.
- ex_mem_to_reg  in  1  writeback selects LMD.
- ex_rd  in  REG_ADDR_W  destination register.
- mem_stall  out  1  upstream must hold EX/MEM.
- dmem_req  out  1  access request.
- dmem_we  out  1  store.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_rdata  in  XLEN  load word, valid with dmem_ready.
- dmem_ready  in  1  access completes this cycle.
- wb_valid  out  1  MEM/WB valid.
- wb_address  out  XLEN  ALU result to writeback.
- wb_lmd  out  XLEN  formatted load data.
- wb_mem_to_reg  out  1  writeback select.
- wb_rd  out  REG_ADDR_W  destination.
- wb_reg_write  out  1  register write enable.
- mem_misalign  out  1  misaligned-access pulse.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state IDLE. All wb_* outputs 0. dmem_req, dmem_we, dmem_be, mem_misalign 0. Captured request registers 0.
- FSM has two states, IDLE and ACCESS.
- IDLE, ex_valid=0: next cycle wb_valid=0 and wb_reg_write=0.
- IDLE, ex_valid=1, not mem op:
  - Next edge loads wb_address=ex_alu_result, wb_rd, wb_reg_write, wb_mem_to_reg; wb_lmd=0; wb_valid=1.
  - Latency 1 cycle, no stall.
- IDLE, ex_valid=1, mem op (mem_read|mem_write):
  - mem_stall=1 combinationally.
  - Edge captures address, store data, funct3, rd, controls; state goes to ACCESS; wb_valid=0 next cycle.
- ACCESS:
  - dmem_req=1. dmem_addr, dmem_we, dmem_wdata, dmem_be are driven from captured registers and held stable until dmem_ready.
  - mem_stall = ~dmem_ready.
  - On dmem_ready=1: the edge writes MEM/WB (load: wb_lmd=formatted dmem_rdata; store: wb_lmd=0, wb_reg_write=0), sets wb_valid=1, and returns to IDLE.
  - Minimum mem-op latency: 2 cycles. Inputs are ignored while in ACCESS.
- ex_mem_read and ex_mem_write both 1: treated as load, store suppressed.
- Load formatting, with lane = addr[1:0]:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: halfword at addr[1] ? [31:16] : [15:0], sign- or zero-extended.
  - LW: whole word.
- Store formatting:
  - SB: wdata = {4{byte}}, be = 4'b0001<<lane.
  - SH: wdata = {2{half}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: be = 4'b1111.
- Unknown funct3: treated as word access.
- Reset in ACCESS: state returns to IDLE, dmem_req drops next cycle, the pending access is abandoned, no wb_valid.
- dmem_ready while not in ACCESS is ignored.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) access in IDLE gets no ACCESS and no dmem_req.
  - Next edge: wb_valid=1, wb_reg_write=0, mem_misalign=1 for one cycle.
  - No stall.
- Undefined: low address bits are forced to alignment (half clears bit0, word clears [1:0]) and the access proceeds normally. mem_misalign is tied to 0.

Decomposition:
- riscv_pkg holds:
  - funct3 load/store encodings (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW).
  - mem_state_e enum {IDLE, ACCESS}.
  - mem_wb_t struct for the MEM/WB bundle.
- Sub-module mem_align: purely combinational load-extract/sign-extend and store lane/byte-enable generation, shared by both paths.

Test Plan:
- ALU passthrough: ex_valid=1, ex_alu_result=32'h12345678, rd=1, reg_write=1, mem_to_reg=0 -> one cycle later wb_valid=1, wb_address=32'h12345678, mem_stall never 1.
- LW with 2-cycle ready delay: addr=32'h100, dmem_rdata=32'h87654321 -> dmem_req held 3 cycles, mem_stall 1 until ready, then wb_lmd=32'h87654321, wb_mem_to_reg=1.
- LB/LBU: addr=32'h103, rdata=32'h80FF_FFFF -> LB gives wb_lmd=32'hFFFFFF80, LBU gives 32'h00000080.
- SB: addr=32'h202, store_data=32'h000000AB -> dmem_we=1, dmem_be=4'b0100, dmem_wdata=32'hABABABAB, wb_reg_write=0.
- Reset while in ACCESS with dmem_ready=0 -> next cycle dmem_req=0, state IDLE, wb_valid=0, no writeback produced.
- Misaligned LW at 32'h101: with MEM_STAGE_MISALIGN_TRAP_EN -> no dmem_req, mem_misalign=1 one cycle, wb_reg_write=0. Without the macro -> dmem_addr=32'h100, normal load.
